// File: rtl/slot_param_sequencer_pkg.sv
// Shared types, address map and the built-in YM2413 voice ROM for slot_param_sequencer.
// Build option RHYTHM_EN adds the three rhythm patches (ROM entries 16-18).
package slot_param_sequencer_pkg;

  localparam int NSLOT = 18;
  localparam int NCH   = NSLOT / 2;
  localparam logic [3:0] SUS_RR = 4'd5;

`ifdef RHYTHM_EN
  localparam int NPATCH = 19;
  localparam logic [7:0] ADDR_RHYTHM = 8'h0E;
`else
  localparam int NPATCH = 16;
`endif
  localparam int PATCH_W = $clog2(NPATCH);

  localparam logic [7:0] ADDR_USER_HI = 8'h07;
  localparam logic [7:0] ADDR_FNUM_LO = 8'h10;
  localparam logic [7:0] ADDR_FNUM_HI = 8'h18;
  localparam logic [7:0] ADDR_CTRL_LO = 8'h20;
  localparam logic [7:0] ADDR_CTRL_HI = 8'h28;
  localparam logic [7:0] ADDR_INST_LO = 8'h30;
  localparam logic [7:0] ADDR_INST_HI = 8'h38;

  typedef struct packed {
    logic       am;
    logic       pm;
    logic       eg;
    logic       ksr;
    logic [3:0] mult;
    logic [1:0] ksl;
    logic [5:0] tl;
    logic [3:0] ar;
    logic [3:0] dr;
    logic [3:0] sl;
    logic [3:0] rr;
  } PATCH_TYPE;

  // Register-order patch bytes; entry 0 stands in for the user patch and is never read.
  localparam logic [7:0] VOICE_ROM [NPATCH][8] = '{
    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h71, 8'h61, 8'h1E, 8'h17, 8'hD0, 8'h78, 8'h00, 8'h17},
    '{8'h13, 8'h41, 8'h1A, 8'h0D, 8'hD8, 8'hF7, 8'h23, 8'h13},
    '{8'h13, 8'h01, 8'h99, 8'h00, 8'hF2, 8'hC4, 8'h21, 8'h23},
    '{8'h11, 8'h61, 8'h0E, 8'h07, 8'h8D, 8'h64, 8'h70, 8'h27},
    '{8'h32, 8'h21, 8'h1E, 8'h06, 8'hE1, 8'h76, 8'h01, 8'h28},
    '{8'h31, 8'h22, 8'h16, 8'h05, 8'hE0, 8'h71, 8'h00, 8'h18},
    '{8'h21, 8'h61, 8'h1D, 8'h07, 8'h82, 8'h81, 8'h11, 8'h07},
    '{8'h33, 8'h21, 8'h2D, 8'h13, 8'hB0, 8'h70, 8'h00, 8'h07},
    '{8'h61, 8'h61, 8'h1B, 8'h06, 8'h64, 8'h65, 8'h10, 8'h17},
    '{8'h41, 8'h61, 8'h0B, 8'h18, 8'h85, 8'hF0, 8'h81, 8'h07},
    '{8'h33, 8'h01, 8'h83, 8'h11, 8'hEA, 8'hEF, 8'h10, 8'h04},
    '{8'h17, 8'hC1, 8'h24, 8'h07, 8'hF8, 8'hF8, 8'h22, 8'h12},
    '{8'h61, 8'h50, 8'h0C, 8'h05, 8'hD2, 8'hF5, 8'h40, 8'h16},
    '{8'h01, 8'h01, 8'h55, 8'h03, 8'hE9, 8'h90, 8'h03, 8'h02},
    '{8'h41, 8'h41, 8'h89, 8'h03, 8'hF1, 8'hE4, 8'hC0, 8'h13}
`ifdef RHYTHM_EN
   ,'{8'h01, 8'h01, 8'h18, 8'h0F, 8'hDF, 8'hF8, 8'h6A, 8'h6D},
    '{8'h01, 8'h01, 8'h00, 8'h00, 8'hC8, 8'hD8, 8'hA7, 8'h68},
    '{8'h05, 8'h01, 8'h00, 8'h00, 8'hF8, 8'hAA, 8'h59, 8'h55}
`endif
  };

endpackage

// File: rtl/slot_param_sequencer_patch_decode.sv
// Splits the eight raw patch bytes into the operator fields for a modulator or carrier slot.
module slot_param_sequencer_patch_decode
  import slot_param_sequencer_pkg::*;
(
  input  logic [7:0][7:0] i_bytes,
  input  logic            i_carrier,
  output PATCH_TYPE       o_fields
);

  logic [7:0] w_ctl;
  logic [7:0] w_env;
  logic [7:0] w_lvl;
  logic       w_unused;

  // Bytes come in mod/car pairs; only TL is modulator-only and KSL lives in two places.
  always_comb begin
    w_ctl = i_carrier ? i_bytes[1] : i_bytes[0];
    w_env = i_carrier ? i_bytes[5] : i_bytes[4];
    w_lvl = i_carrier ? i_bytes[7] : i_bytes[6];
    o_fields.am   = w_ctl[7];
    o_fields.pm   = w_ctl[6];
    o_fields.eg   = w_ctl[5];
    o_fields.ksr  = w_ctl[4];
    o_fields.mult = w_ctl[3:0];
    o_fields.ksl  = i_carrier ? i_bytes[3][7:6] : i_bytes[2][7:6];
    o_fields.tl   = i_bytes[2][5:0];
    o_fields.ar   = w_env[7:4];
    o_fields.dr   = w_env[3:0];
    o_fields.sl   = w_lvl[7:4];
    o_fields.rr   = w_lvl[3:0];
  end

  assign w_unused = ^i_bytes[3][5:0];

endmodule

// File: rtl/slot_param_sequencer.sv
// YM2413-style register file and slot sequencer feeding per-slot EG parameters.
// Build option RHYTHM_EN enables reg 0x0E and rhythm-mode patch/key/TL handling.
module slot_param_sequencer
  import slot_param_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clkena,
  input  logic       i_cpu_wr,
  input  logic       i_cpu_a,
  input  logic [7:0] i_cpu_d,
  output logic [4:0] o_slot,
  output logic [1:0] o_stage,
  output logic       o_rhythm,
  output logic       o_am,
  output logic [6:0] o_tl,
  output logic [3:0] o_ar,
  output logic [3:0] o_dr,
  output logic [3:0] o_sl,
  output logic [3:0] o_rr,
  output logic [3:0] o_rks,
  output logic       o_key
);

  logic [4:0] r_slot;
  logic [1:0] r_stage;
  logic [7:0] r_addr;
  logic [7:0] r_user  [8];
  logic [8:0] r_fnum  [NCH];
  logic [2:0] r_block [NCH];
  logic       r_key   [NCH];
  logic       r_sus   [NCH];
  logic [3:0] r_inst  [NCH];
  logic [3:0] r_vol   [NCH];
`ifdef RHYTHM_EN
  logic [5:0] r_rhythmReg;
`endif

  logic [3:0]         w_wrCh;
  logic               w_wrChValid;
  logic [3:0]         w_ch;
  logic               w_car;
  logic [PATCH_W-1:0] w_patchNum;
  logic [7:0][7:0]    w_raw;
  PATCH_TYPE          w_patch;
  logic               w_key;
  logic [6:0]         w_tl;
  logic [3:0]         w_rr;
  logic [3:0]         w_rks;
  logic               w_unused;

  assign o_slot      = r_slot;
  assign o_stage     = r_stage;
  assign w_wrCh      = r_addr[3:0];
  assign w_wrChValid = (r_addr[3:0] < 4'd9);
  assign w_ch        = r_slot[4:1];
  assign w_car       = r_slot[0];

`ifdef RHYTHM_EN
  assign o_rhythm = r_rhythmReg[5];
`else
  assign o_rhythm = 1'b0;
`endif

  // CPU port: address latch plus data writes into the mapped register pages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      for (int i = 0; i < 8; i++) r_user[i] <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_fnum[i]  <= '0;
        r_block[i] <= '0;
        r_key[i]   <= 1'b0;
        r_sus[i]   <= 1'b0;
        r_inst[i]  <= '0;
        r_vol[i]   <= '0;
      end
`ifdef RHYTHM_EN
      r_rhythmReg <= '0;
`endif
    end else if (i_cpu_wr) begin
      if (!i_cpu_a) begin
        r_addr <= i_cpu_d;
      end else begin
        if (r_addr <= ADDR_USER_HI) r_user[r_addr[2:0]] <= i_cpu_d;
`ifdef RHYTHM_EN
        if (r_addr == ADDR_RHYTHM) r_rhythmReg <= i_cpu_d[5:0];
`endif
        if (r_addr >= ADDR_FNUM_LO && r_addr <= ADDR_FNUM_HI) r_fnum[w_wrCh][7:0] <= i_cpu_d;
        if (r_addr >= ADDR_CTRL_LO && r_addr <= ADDR_CTRL_HI) begin
          r_sus[w_wrCh]     <= i_cpu_d[5];
          r_key[w_wrCh]     <= i_cpu_d[4];
          r_block[w_wrCh]   <= i_cpu_d[3:1];
          r_fnum[w_wrCh][8] <= i_cpu_d[0];
        end
        if (r_addr >= ADDR_INST_LO && r_addr <= ADDR_INST_HI && w_wrChValid) begin
          r_inst[w_wrCh] <= i_cpu_d[7:4];
          r_vol[w_wrCh]  <= i_cpu_d[3:0];
        end
      end
    end
  end

  // Rhythm channels 6..8 map onto ROM patches 16..18 regardless of their instrument.
  always_comb begin
    w_patchNum = PATCH_W'(r_inst[w_ch]);
`ifdef RHYTHM_EN
    if (r_rhythmReg[5] && w_ch >= 4'd6) w_patchNum = 5'(w_ch) + 5'd10;
`endif
    for (int b = 0; b < 8; b++)
      w_raw[b] = (w_patchNum == '0) ? r_user[b] : VOICE_ROM[w_patchNum][b];
  end

  slot_param_sequencer_patch_decode u_patch_decode (
    .i_bytes  (w_raw),
    .i_carrier(w_car),
    .o_fields (w_patch)
  );

  always_comb begin
    w_key = r_key[w_ch];
    w_tl  = w_car ? {r_vol[w_ch], 3'b000} : {w_patch.tl, 1'b0};
`ifdef RHYTHM_EN
    if (r_rhythmReg[5]) begin
      case (r_slot)
        5'd12, 5'd13: w_key = w_key | r_rhythmReg[4];
        5'd14: begin
          w_key = w_key | r_rhythmReg[0];
          w_tl  = {r_inst[7], 3'b000};
        end
        5'd15: w_key = w_key | r_rhythmReg[3];
        5'd16: begin
          w_key = w_key | r_rhythmReg[2];
          w_tl  = {r_inst[8], 3'b000};
        end
        5'd17: w_key = w_key | r_rhythmReg[1];
        default: ;
      endcase
    end
`endif
    // EG=1 holds at sustain while keyed; sus forces a slow release after key-off.
    if (w_key)             w_rr = w_patch.eg ? 4'd0 : w_patch.rr;
    else if (r_sus[w_ch])  w_rr = SUS_RR;
    else                   w_rr = w_patch.eg ? w_patch.rr : 4'd7;
    w_rks = w_patch.ksr ? {r_block[w_ch], r_fnum[w_ch][8]} : {2'b00, r_block[w_ch][2:1]};
  end

  always_comb begin
    w_unused = ^{w_patch.pm, w_patch.mult, w_patch.ksl};
    for (int i = 0; i < NCH; i++) w_unused = w_unused ^ (^r_fnum[i][7:0]);
  end

  // Parameters fetched at stage 3 of a slot are presented while the counter shows the next slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot  <= '0;
      r_stage <= '0;
      o_am    <= 1'b0;
      o_tl    <= '0;
      o_ar    <= '0;
      o_dr    <= '0;
      o_sl    <= '0;
      o_rr    <= '0;
      o_rks   <= '0;
      o_key   <= 1'b0;
    end else if (i_clkena) begin
      r_stage <= r_stage + 2'd1;
      if (r_stage == 2'd3) begin
        r_slot <= (r_slot == 5'(NSLOT - 1)) ? 5'd0 : r_slot + 5'd1;
        o_am   <= w_patch.am;
        o_tl   <= w_tl;
        o_ar   <= w_patch.ar;
        o_dr   <= w_patch.dr;
        o_sl   <= w_patch.sl;
        o_rr   <= w_rr;
        o_rks  <= w_rks;
        o_key  <= w_key;
      end
    end
  end

endmodule

// File: tb/tb_slot_param_sequencer.sv
// Directed bench for slot_param_sequencer; rhythm checks follow the RHYTHM_EN build option.
`timescale 1ns/1ps
module tb_slot_param_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       clkena;
  logic       cpuWr;
  logic       cpuA;
  logic [7:0] cpuD;
  logic [4:0] slot;
  logic [1:0] stage;
  logic       rhythm;
  logic       am;
  logic [6:0] tl;
  logic [3:0] ar, dr, sl, rr, rks;
  logic       key;

  int testsRun    = 0;
  int testsFailed = 0;
  int pos         = 0;

  always #5 clk = ~clk;

  slot_param_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .i_clkena(clkena),
    .i_cpu_wr(cpuWr),
    .i_cpu_a (cpuA),
    .i_cpu_d (cpuD),
    .o_slot  (slot),
    .o_stage (stage),
    .o_rhythm(rhythm),
    .o_am    (am),
    .o_tl    (tl),
    .o_ar    (ar),
    .o_dr    (dr),
    .o_sl    (sl),
    .o_rr    (rr),
    .o_rks   (rks),
    .o_key   (key)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkParams(input string tag, input logic eAm, input logic [6:0] eTl,
                             input logic [3:0] eAr, eDr, eSl, eRr, eRks, input logic eKey);
    checkOutput({tag, ".am"},  32'(am),  32'(eAm));
    checkOutput({tag, ".tl"},  32'(tl),  32'(eTl));
    checkOutput({tag, ".ar"},  32'(ar),  32'(eAr));
    checkOutput({tag, ".dr"},  32'(dr),  32'(eDr));
    checkOutput({tag, ".sl"},  32'(sl),  32'(eSl));
    checkOutput({tag, ".rr"},  32'(rr),  32'(eRr));
    checkOutput({tag, ".rks"}, 32'(rks), 32'(eRks));
    checkOutput({tag, ".key"}, 32'(key), 32'(eKey));
  endtask

  // One clock with the given inputs; pos tracks clkena edges modulo one frame.
  task automatic applyStimulus(input logic ce, input logic wr, input logic a, input logic [7:0] d);
    clkena = ce;
    cpuWr  = wr;
    cpuA   = a;
    cpuD   = d;
    @(posedge clk);
    #1;
    clkena = 1'b0;
    cpuWr  = 1'b0;
    cpuA   = 1'b0;
    cpuD   = 8'h00;
    if (ce) pos = (pos + 1) % 72;
  endtask

  task automatic cpuWrite(input logic [7:0] addr, input logic [7:0] data);
    applyStimulus(1'b0, 1'b1, 1'b0, addr);
    applyStimulus(1'b0, 1'b1, 1'b1, data);
  endtask

  task automatic gotoFetch(input int s);
    int target;
    target = (4 * s + 4) % 72;
    do applyStimulus(1'b1, 1'b0, 1'b0, 8'h00); while (pos != target);
  endtask

  initial begin
    reset  = 1'b1;
    clkena = 1'b0;
    cpuWr  = 1'b0;
    cpuA   = 1'b0;
    cpuD   = 8'h00;
    #3;
    checkOutput("reset.slot", 32'(slot), 32'd0);
    checkOutput("reset.stage", 32'(stage), 32'd0);
    checkOutput("reset.rhythm", 32'(rhythm), 32'd0);
    checkParams("reset", 1'b0, 7'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    #9 reset = 1'b0;

    for (int i = 1; i <= 72; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput($sformatf("seq%0d.slot", i), 32'(slot), 32'(pos / 4));
      checkOutput($sformatf("seq%0d.stage", i), 32'(stage), 32'(pos % 4));
      if (i == 3) checkParams("prefetch", 1'b0, 7'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      if (i == 4) checkParams("firstfetch", 1'b0, 7'h00, 4'h0, 4'h0, 4'h0, 4'h7, 4'h0, 1'b0);
    end
    checkOutput("wrap.slot", 32'(slot), 32'd0);

    cpuWrite(8'h30, 8'h00);
    cpuWrite(8'h04, 8'hF3);
    cpuWrite(8'h05, 8'hA2);
    cpuWrite(8'h01, 8'h10);
    cpuWrite(8'h20, 8'h1D);
    gotoFetch(0);
    checkParams("user.s0", 1'b0, 7'h00, 4'hF, 4'h3, 4'h0, 4'h0, 4'h3, 1'b1);
    gotoFetch(1);
    checkParams("user.s1", 1'b0, 7'h00, 4'hA, 4'h2, 4'h0, 4'h0, 4'hD, 1'b1);

    cpuWrite(8'h31, 8'h1A);
    cpuWrite(8'h32, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hC3);
    gotoFetch(2);
    checkParams("rom1.s2", 1'b0, 7'h3C, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    gotoFetch(3);
    checkParams("rom1.s3", 1'b0, 7'h50, 4'h7, 4'h8, 4'h1, 4'h7, 4'h0, 1'b0);
    gotoFetch(4);
    checkParams("rom12.s4", 1'b0, 7'h48, 4'hF, 4'h8, 4'h2, 4'h7, 4'h0, 1'b0);
    gotoFetch(5);
    checkParams("rom12.s5", 1'b1, 7'h18, 4'hF, 4'h8, 4'h1, 4'h7, 4'h0, 1'b0);

    cpuWrite(8'h19, 8'hFF);
    cpuWrite(8'h29, 8'hFF);
    cpuWrite(8'h39, 8'hFF);
    gotoFetch(1);
    checkParams("unmap.s1", 1'b0, 7'h00, 4'hA, 4'h2, 4'h0, 4'h0, 4'hD, 1'b1);
    gotoFetch(3);
    checkParams("unmap.s3", 1'b0, 7'h50, 4'h7, 4'h8, 4'h1, 4'h7, 4'h0, 1'b0);
    gotoFetch(17);
    checkParams("unmap.s17", 1'b0, 7'h00, 4'hA, 4'h2, 4'h0, 4'h7, 4'h0, 1'b0);

    cpuWrite(8'h20, 8'h20);
    gotoFetch(0);
    checkParams("sus.s0", 1'b0, 7'h00, 4'hF, 4'h3, 4'h0, 4'h5, 4'h0, 1'b0);
    gotoFetch(1);
    checkParams("sus.s1", 1'b0, 7'h00, 4'hA, 4'h2, 4'h0, 4'h5, 4'h0, 1'b0);
    cpuWrite(8'h20, 8'h00);
    gotoFetch(0);
    checkParams("nosus.s0", 1'b0, 7'h00, 4'hF, 4'h3, 4'h0, 4'h7, 4'h0, 1'b0);
    gotoFetch(1);
    checkParams("nosus.s1", 1'b0, 7'h00, 4'hA, 4'h2, 4'h0, 4'h7, 4'h0, 1'b0);
    cpuWrite(8'h07, 8'h4B);
    cpuWrite(8'h01, 8'h30);
    gotoFetch(1);
    checkParams("egoff.s1", 1'b0, 7'h00, 4'hA, 4'h2, 4'h4, 4'hB, 4'h0, 1'b0);
    cpuWrite(8'h20, 8'h10);
    gotoFetch(1);
    checkParams("eghold.s1", 1'b0, 7'h00, 4'hA, 4'h2, 4'h4, 4'h0, 4'h0, 1'b1);

    cpuWrite(8'h0E, 8'h21);
    cpuWrite(8'h37, 8'h50);
    gotoFetch(14);
`ifdef RHYTHM_EN
    checkOutput("rhy.rhythm", 32'(rhythm), 32'd1);
    checkParams("rhy.s14", 1'b0, 7'h28, 4'hC, 4'h8, 4'hA, 4'h7, 4'h0, 1'b1);
    gotoFetch(15);
    checkParams("rhy.s15", 1'b0, 7'h00, 4'hD, 4'h8, 4'h6, 4'h7, 4'h0, 1'b0);
`else
    checkOutput("norhy.rhythm", 32'(rhythm), 32'd0);
    checkParams("norhy.s14", 1'b0, 7'h3C, 4'hE, 4'h1, 4'h0, 4'h1, 4'h0, 1'b0);
    gotoFetch(15);
    checkParams("norhy.s15", 1'b0, 7'h00, 4'h7, 4'h6, 4'h2, 4'h8, 4'h0, 1'b0);
`endif

    applyStimulus(1'b0, 1'b1, 1'b0, 8'h31);
    while (pos != 15) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h1F);
    checkOutput("sameedge.old_tl", 32'(tl), 32'h50);
    gotoFetch(3);
    checkOutput("sameedge.new_tl", 32'(tl), 32'h78);
    checkOutput("sameedge.ar", 32'(ar), 32'h7);

    gotoFetch(5);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst.slot", 32'(slot), 32'd0);
    checkOutput("midrst.stage", 32'(stage), 32'd0);
    checkOutput("midrst.rhythm", 32'(rhythm), 32'd0);
    checkParams("midrst", 1'b0, 7'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    reset = 1'b0;
    pos = 0;
    gotoFetch(3);
    checkOutput("postrst.slot", 32'(slot), 32'd4);
    checkOutput("postrst.stage", 32'(stage), 32'd0);
    checkParams("postrst.s3", 1'b0, 7'h00, 4'h0, 4'h0, 4'h0, 4'h7, 4'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
